// File: rtl/seg_hex595_mux.sv
// seg_hex595_mux: scans DIGITS hex digits into a 74HC595 chain, one {seg, sel} word per digit.
// Define SEG_HEX595_LZ_BLANK_EN to enable leading-zero suppression.
//
// state  | meaning
// LOAD   | build {seg, sel} word; snapshot data/dp/blank when dig == 0
// SHIFT  | clock 16 bits out, MSB first
// STROBE | seg_str high to latch the 595 outputs
// HOLD   | keep the digit lit, then advance dig
module seg_hex595_mux #(
    parameter int DIGITS   = 8,
    parameter int CLK_DIV  = 4,
    parameter int HOLD_CYC = 1000
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [4*DIGITS-1:0] data,
    input  logic [DIGITS-1:0]   dp,
    input  logic [DIGITS-1:0]   blank,
    output logic                seg_clk,
    output logic                seg_dat,
    output logic                seg_str,
    output logic                frame_done
);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);
    localparam logic [PW-1:0] PH_INIT   = PW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);

    typedef enum logic [1:0] {LOAD, SHIFT, STROBE, HOLD} state_t;

    state_t              state_q, state_d;
    logic [DW-1:0]       dig_q, dig_d, dig_nxt;
    logic [PW-1:0]       ph_q, ph_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [3:0]          bit_q, bit_d;
    logic [15:0]         sh_q, sh_d;
    logic [4*DIGITS-1:0] data_sh_q, data_sh_d, src_data;
    logic [DIGITS-1:0]   dp_sh_q, dp_sh_d, src_dp;
    logic [DIGITS-1:0]   blank_sh_q, blank_sh_d, src_blank;
    logic [DIGITS-1:0]   dark;
    logic                seg_clk_q, seg_clk_d;
    logic                seg_dat_q, seg_dat_d;
    logic                seg_str_q, seg_str_d;
    logic                frame_done_q, frame_done_d;
    logic [3:0]          nib;
    logic [7:0]          seg, sel;
    logic [15:0]         word;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F;
            4'h1: p = 7'h06;
            4'h2: p = 7'h5B;
            4'h3: p = 7'h4F;
            4'h4: p = 7'h66;
            4'h5: p = 7'h6D;
            4'h6: p = 7'h7D;
            4'h7: p = 7'h07;
            4'h8: p = 7'h7F;
            4'h9: p = 7'h6F;
            4'hA: p = 7'h77;
            4'hB: p = 7'h7C;
            4'hC: p = 7'h39;
            4'hD: p = 7'h5E;
            4'hE: p = 7'h79;
            default: p = 7'h71;
        endcase
        return p;
    endfunction

    // Digit 0 reads the live inputs in the same cycle they are snapshotted.
    always_comb begin
        src_data  = (dig_q == '0) ? data  : data_sh_q;
        src_dp    = (dig_q == '0) ? dp    : dp_sh_q;
        src_blank = (dig_q == '0) ? blank : blank_sh_q;
    end

`ifdef SEG_HEX595_LZ_BLANK_EN
    logic [DIGITS-1:0] lz_sup;
    logic              lz_run;

    always_comb begin
        lz_sup = '0;
        lz_run = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            lz_run    = lz_run & (src_data[4*k +: 4] == 4'h0) & ~src_dp[k];
            lz_sup[k] = lz_run;
        end
    end

    assign dark = src_blank | lz_sup;
`else
    assign dark = src_blank;
`endif

    always_comb begin
        nib  = src_data[{dig_q, 2'b00} +: 4];
        seg  = dark[dig_q] ? 8'hFF : ~{src_dp[dig_q], hex7(nib)};
        sel  = 8'h01 << dig_q;
        word = {seg, sel};
    end

    assign dig_nxt = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        dig_d        = dig_q;
        ph_d         = ph_q;
        hold_d       = hold_q;
        bit_d        = bit_q;
        sh_d         = sh_q;
        data_sh_d    = data_sh_q;
        dp_sh_d      = dp_sh_q;
        blank_sh_d   = blank_sh_q;
        seg_clk_d    = seg_clk_q;
        seg_dat_d    = seg_dat_q;
        seg_str_d    = seg_str_q;
        frame_done_d = 1'b0;
        case (state_q)
            LOAD: begin
                if (dig_q == '0) begin
                    data_sh_d  = data;
                    dp_sh_d    = dp;
                    blank_sh_d = blank;
                end
                sh_d      = word;
                seg_dat_d = word[15];
                seg_clk_d = 1'b0;
                ph_d      = PH_INIT;
                bit_d     = 4'd15;
                state_d   = SHIFT;
            end
            SHIFT: begin
                if (ph_q != '0) begin
                    ph_d = ph_q - 1'b1;
                end else begin
                    ph_d = PH_INIT;
                    if (!seg_clk_q) begin
                        seg_clk_d = 1'b1;
                    end else if (bit_q == 4'd0) begin
                        seg_clk_d = 1'b0;
                        seg_str_d = 1'b1;
                        state_d   = STROBE;
                    end else begin
                        seg_clk_d = 1'b0;
                        seg_dat_d = sh_q[14];
                        sh_d      = {sh_q[14:0], 1'b0};
                        bit_d     = bit_q - 1'b1;
                    end
                end
            end
            STROBE: begin
                if (ph_q != '0) begin
                    ph_d = ph_q - 1'b1;
                end else begin
                    seg_str_d    = 1'b0;
                    frame_done_d = (dig_q == DIG_LAST);
                    if (HOLD_CYC == 0) begin
                        dig_d   = dig_nxt;
                        state_d = LOAD;
                    end else begin
                        hold_d  = HOLD_INIT;
                        state_d = HOLD;
                    end
                end
            end
            default: begin
                if (hold_q != '0) begin
                    hold_d = hold_q - 1'b1;
                end else begin
                    dig_d   = dig_nxt;
                    state_d = LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= LOAD;
            dig_q        <= '0;
            ph_q         <= '0;
            hold_q       <= '0;
            bit_q        <= '0;
            sh_q         <= '0;
            data_sh_q    <= '0;
            dp_sh_q      <= '0;
            blank_sh_q   <= '0;
            seg_clk_q    <= 1'b0;
            seg_dat_q    <= 1'b0;
            seg_str_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dig_q        <= dig_d;
            ph_q         <= ph_d;
            hold_q       <= hold_d;
            bit_q        <= bit_d;
            sh_q         <= sh_d;
            data_sh_q    <= data_sh_d;
            dp_sh_q      <= dp_sh_d;
            blank_sh_q   <= blank_sh_d;
            seg_clk_q    <= seg_clk_d;
            seg_dat_q    <= seg_dat_d;
            seg_str_q    <= seg_str_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_clk    = seg_clk_q;
    assign seg_dat    = seg_dat_q;
    assign seg_str    = seg_str_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_hex595_mux.sv
// Bench for seg_hex595_mux: table of per-frame input vectors with expected 595 words,
// scoreboarded against words reassembled from seg_clk/seg_dat/seg_str.
module tb_seg_hex595_mux;
    localparam int DIGITS   = 4;
    localparam int CLK_DIV  = 2;
    localparam int HOLD_CYC = 8;
    localparam int DIG_PER  = 1 + 32*CLK_DIV + CLK_DIV + HOLD_CYC;

`ifdef SEG_HEX595_LZ_BLANK_EN
    localparam logic [15:0] Z2 = 16'hFF04;
    localparam logic [15:0] Z3 = 16'hFF08;
`else
    localparam logic [15:0] Z2 = 16'hC004;
    localparam logic [15:0] Z3 = 16'hC008;
`endif

    typedef struct packed {
        logic [15:0]      d;
        logic [3:0]       p;
        logic [3:0]       b;
        logic [3:0][15:0] w;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b0;
    logic [15:0] data  = '0;
    logic [3:0]  dp    = '0;
    logic [3:0]  blank = '0;
    logic        seg_clk, seg_dat, seg_str, frame_done;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_q[$];
    vec_t        vecs[6];

    seg_hex595_mux #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .HOLD_CYC(HOLD_CYC)) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .data       (data),
        .dp         (dp),
        .blank      (blank),
        .seg_clk    (seg_clk),
        .seg_dat    (seg_dat),
        .seg_str    (seg_str),
        .frame_done (frame_done)
    );

    always #10 sys_clk = ~sys_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push_words(input logic [3:0][15:0] w);
        for (int k = 0; k < 4; k++) exp_q.push_back(w[k]);
    endtask

    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!frame_done && n < 400);
        check("frame_done_seen", frame_done, 1);
    endtask

    task automatic wait_rises(input bit on_str, input int count);
        int   seen = 0;
        int   n = 0;
        logic prev;
        prev = on_str ? seg_str : seg_clk;
        while (seen < count && n < 2000) begin
            @(negedge sys_clk);
            n++;
            if ((on_str ? seg_str : seg_clk) && !prev) seen++;
            prev = on_str ? seg_str : seg_clk;
        end
        check("edge_wait", seen, count);
    endtask

    // Monitor: rebuild words, check framing/timing, pop the scoreboard on each strobe.
    int          cyc = 0, dat_age = 0, sh_cnt = 0, str_len = 0;
    int          last_str_cyc = -1, last_fd_cyc = -1;
    logic [15:0] sh_word = '0;
    logic [7:0]  last_sel = '0;
    logic        p_clk = 1'b0, p_dat = 1'b0, p_str = 1'b0, p_fd = 1'b0;

    always @(negedge sys_clk) begin
        cyc++;
        if (sys_rst) begin
            check("reset_outputs", {seg_clk, seg_dat, seg_str, frame_done}, 0);
            exp_q.delete();
            sh_cnt = 0; str_len = 0; dat_age = 0;
            last_str_cyc = -1; last_fd_cyc = -1;
        end else begin
            dat_age = (seg_dat !== p_dat) ? 1 : dat_age + 1;
            if (seg_str) check("clk_low_in_strobe", seg_clk, 0);
            if (seg_clk && !p_clk) begin
                check("dat_setup", dat_age > CLK_DIV, 1);
                sh_word = {sh_word[14:0], seg_dat};
                sh_cnt++;
            end
            if (seg_str && !p_str) begin
                check("bits_per_word", sh_cnt, 16);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL word_unexpected: got %h, required none", sh_word);
                end else begin
                    check("word", sh_word, exp_q.pop_front());
                end
                if (last_str_cyc >= 0) check("digit_period", cyc - last_str_cyc, DIG_PER);
                last_str_cyc = cyc;
                last_sel = sh_word[7:0];
                sh_cnt = 0;
            end
            if (seg_str) str_len++;
            if (!seg_str && p_str) begin
                check("strobe_len", str_len, CLK_DIV);
                str_len = 0;
            end
            if (frame_done) begin
                check("fd_after_last_strobe", {p_str, last_sel}, {1'b1, 8'h08});
                check("fd_one_cycle", p_fd, 0);
                if (last_fd_cyc >= 0) check("frame_period", cyc - last_fd_cyc, DIGITS*DIG_PER);
                last_fd_cyc = cyc;
            end
        end
        p_clk = seg_clk;
        p_dat = seg_dat;
        p_str = seg_str;
        p_fd  = frame_done;
    end

    initial begin
        vecs[0] = {16'h1A3F, 4'b0000, 4'b0000, 16'hF908, 16'h8804, 16'hB002, 16'h8E01};
        vecs[1] = {16'h0000, 4'b0010, 4'b1000, 16'hFF08, Z2,       16'h4002, 16'hC001};
        vecs[2] = {16'h0050, 4'b0000, 4'b0000, Z3,       Z2,       16'h9202, 16'hC001};
        vecs[3] = {16'h8E6B, 4'b0101, 4'b0000, 16'h8008, 16'h0604, 16'h8202, 16'h0301};
        vecs[4] = {16'h97CD, 4'b1111, 4'b0110, 16'h1008, 16'hFF04, 16'hFF02, 16'h2101};
        vecs[5] = {16'hC740, 4'b0000, 4'b0000, 16'hC608, 16'hF804, 16'h9902, 16'hC001};

        #1 sys_rst = 1'b1;
        data = vecs[0].d; dp = vecs[0].p; blank = vecs[0].b;
        repeat (3) @(negedge sys_clk);
        #1 sys_rst = 1'b0;
        push_words(vecs[0].w);

        for (int i = 1; i < 6; i++) begin
            wait_frame();
            data = vecs[i].d; dp = vecs[i].p; blank = vecs[i].b;
            push_words(vecs[i].w);
        end
        wait_frame();

        // Snapshot coherence: change data mid-frame (during digit 2).
        data = 16'h1111; dp = '0; blank = '0;
        push_words({16'hF908, 16'hF904, 16'hF902, 16'hF901});
        wait_frame();
        push_words({16'hF908, 16'hF904, 16'hF902, 16'hF901});
        wait_rises(1'b1, 2);
        repeat (20) @(negedge sys_clk);
        data = 16'h2222;
        push_words({16'hA408, 16'hA404, 16'hA402, 16'hA401});
        wait_frame();
        wait_frame();

        // Reset during bit 7 of digit 1, then restart from digit 0.
        push_words({16'hA408, 16'hA404, 16'hA402, 16'hA401});
        wait_rises(1'b1, 1);
        wait_rises(1'b0, 9);
        check("clk_high_before_reset", seg_clk, 1);
        #1 sys_rst = 1'b1;
        #1 check("reset_async", {seg_clk, seg_dat, seg_str, frame_done}, 0);
        data = vecs[0].d; dp = vecs[0].p; blank = vecs[0].b;
        repeat (5) @(negedge sys_clk);
        #1 sys_rst = 1'b0;
        push_words(vecs[0].w);
        wait_frame();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
